// File: rtl/jt5205_enc.sv
// Serial 4-bit OKI/MSM5205 ADPCM encoder: one compare/subtract step per cen cycle.
// Optional macro JT5205_ENC_RECON_EN exposes the reconstructed predictor on recon.
module jt5205_enc #(
  parameter int STEP_IDX0 = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [11:0] pcm,
  input  logic        pcm_valid,
  output logic        ready,
  output logic [3:0]  code,
  output logic        code_valid,
  output logic [11:0] recon
);

  typedef enum logic [2:0] {IDLE, B2, B1, B0, UPD} state_t;

  localparam logic [10:0] STEP_TBL [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  state_t             state_q, state_d;
  logic signed [11:0] pred_q, pred_d;
  logic [5:0]         idx_q, idx_d;
  logic [12:0]        mag_q, mag_d;
  logic [12:0]        delta_q, delta_d;
  logic               sign_q, sign_d;
  logic [2:0]         bits_q, bits_d;
  logic [3:0]         code_q, code_d;
  logic               cv_q, cv_d;

  logic [10:0]        step;
  logic [12:0]        cmp_step;
  logic               ge;
  logic signed [12:0] pcm_ext, pred_ext13, diff;
  logic signed [13:0] pred_ext14, delta_ext, pred_sum;
  logic signed [6:0]  idx_adj, idx_sum;

  assign step       = STEP_TBL[idx_q];
  assign pcm_ext    = $signed(pcm);
  assign pred_ext13 = pred_q;
  assign diff       = pcm_ext - pred_ext13;
  assign pred_ext14 = pred_q;
  assign delta_ext  = $signed({1'b0, delta_q});
  assign pred_sum   = sign_q ? (pred_ext14 - delta_ext) : (pred_ext14 + delta_ext);
  assign idx_sum    = $signed({1'b0, idx_q}) + idx_adj;
  assign ge         = (mag_q >= cmp_step);

  // The shared comparator sees step, step/2, step/4 on successive bit states.
  always_comb begin
    cmp_step = {4'd0, step[10:2]};
    case (state_q)
      B2:      cmp_step = {2'd0, step};
      B1:      cmp_step = {3'd0, step[10:1]};
      default: cmp_step = {4'd0, step[10:2]};
    endcase
  end

  always_comb begin
    idx_adj = -7'sd1;
    case (bits_q)
      3'd4:    idx_adj = 7'sd2;
      3'd5:    idx_adj = 7'sd4;
      3'd6:    idx_adj = 7'sd6;
      3'd7:    idx_adj = 7'sd8;
      default: idx_adj = -7'sd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    idx_d   = idx_q;
    mag_d   = mag_q;
    delta_d = delta_q;
    sign_d  = sign_q;
    bits_d  = bits_q;
    code_d  = code_q;
    cv_d    = 1'b0;
    if (cen) begin
      case (state_q)
        IDLE: begin
          if (pcm_valid) begin
            sign_d  = diff[12];
            mag_d   = diff[12] ? 13'(-diff) : 13'(diff);
            delta_d = {5'd0, step[10:3]};
            bits_d  = 3'd0;
            state_d = B2;
          end
        end
        B2, B1, B0: begin
          // Bits shift in MSB-first so bits_q ends as {bit2, bit1, bit0}.
          bits_d = {bits_q[1:0], ge};
          if (ge) begin
            mag_d   = mag_q - cmp_step;
            delta_d = delta_q + cmp_step;
          end
          state_d = (state_q == B2) ? B1 : (state_q == B1) ? B0 : UPD;
        end
        UPD: begin
          if (pred_sum > 14'sd2047)
            pred_d = 12'sd2047;
          else if (pred_sum < -14'sd2048)
            pred_d = -12'sd2048;
          else
            pred_d = pred_sum[11:0];
          if (idx_sum < 7'sd0)
            idx_d = 6'd0;
          else if (idx_sum > 7'sd48)
            idx_d = 6'd48;
          else
            idx_d = idx_sum[5:0];
          code_d  = {sign_q, bits_q};
          cv_d    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pred_q  <= '0;
      idx_q   <= 6'(STEP_IDX0);
      mag_q   <= '0;
      delta_q <= '0;
      sign_q  <= 1'b0;
      bits_q  <= '0;
      code_q  <= '0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pred_q  <= pred_d;
      idx_q   <= idx_d;
      mag_q   <= mag_d;
      delta_q <= delta_d;
      sign_q  <= sign_d;
      bits_q  <= bits_d;
      code_q  <= code_d;
      cv_q    <= cv_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign code       = code_q;
  assign code_valid = cv_q;

`ifdef JT5205_ENC_RECON_EN
  assign recon = pred_q;
`else
  assign recon = '0;
`endif

endmodule

// File: tb/tb_jt5205_enc.sv
// Bench for jt5205_enc: directed test-plan cases plus random samples against an
// arithmetic ADPCM model; recon is checked against the model when JT5205_ENC_RECON_EN is set.
module tb_jt5205_enc;

  logic        clk;
  logic        rst;
  logic        cen;
  logic [11:0] pcm;
  logic        pcm_valid;
  logic        ready;
  logic [3:0]  code;
  logic        code_valid;
  logic [11:0] recon;

  jt5205_enc #(.STEP_IDX0(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .pcm        (pcm),
    .pcm_valid  (pcm_valid),
    .ready      (ready),
    .code       (code),
    .code_valid (code_valid),
    .recon      (recon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tbl [49];
  int adj [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  // model state: committed predictor/index/code, and a pending result
  int m_pred = 0, m_idx = 0, m_code = 0, m_busy = -1;
  int p_code, p_pred, p_idx;
  int cyc = 0, since_acc = 0, obs_lat = -1, pulses = 0;
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic void model_encode(input int sample, output int cd, output int pr, output int ix);
    int step, diff, mag, delta, bits, sgn, th;
    step  = tbl[m_idx];
    diff  = sample - m_pred;
    sgn   = (diff < 0) ? 1 : 0;
    mag   = sgn ? -diff : diff;
    delta = step / 8;
    bits  = 0;
    for (int b = 2; b >= 0; b--) begin
      th = step >> (2 - b);
      if (mag >= th) begin
        bits  = bits | (1 << b);
        mag   = mag - th;
        delta = delta + th;
      end
    end
    pr = clampi(sgn ? m_pred - delta : m_pred + delta, -2048, 2047);
    ix = clampi(m_idx + adj[bits], 0, 48);
    cd = sgn * 8 + bits;
  endfunction

  function automatic int exp_recon();
`ifdef JT5205_ENC_RECON_EN
    return m_pred & 32'hFFF;
`else
    return 0;
`endif
  endfunction

  // One clk edge with the given cen; updates the model and checks all outputs.
  task automatic step(input bit c);
    bit acc;
    bit exp_cv;
    cen = c;
    acc = !rst && c && pcm_valid && (m_busy < 0);
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    exp_cv = 1'b0;
    if (rst) begin
      m_busy = -1; m_pred = 0; m_idx = 0; m_code = 0;
    end else if (acc) begin
      model_encode(int'($signed(pcm)), p_code, p_pred, p_idx);
      m_busy = 0;
      since_acc = 0;
    end else if (c && m_busy >= 0) begin
      m_busy++;
      if (m_busy == 4) begin
        exp_cv = 1'b1;
        m_code = p_code; m_pred = p_pred; m_idx = p_idx;
        m_busy = -1;
      end
    end
    if (c && !acc) since_acc++;
    if (code_valid === 1'b1) begin
      pulses++;
      obs_lat = since_acc;
    end
    chk("code_valid", code_valid, exp_cv);
    chk("code", code, m_code);
    chk("ready", ready, m_busy < 0);
    chk("recon", recon, exp_recon());
    $display("cyc=%0d cen=%0b rst=%0b pcm=%0d valid=%0b acc=%0b ready=%0b code=%h cv=%0b recon=%0d",
             cyc, c, rst, $signed(pcm), pcm_valid, acc, ready, code, code_valid, $signed(recon));
  endtask

  function automatic bit cen_for(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    return ((cyc % mode) == 0);
  endfunction

  task automatic do_reset();
    pcm_valid = 1'b0;
    rst = 1'b1;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;
  endtask

  // Offer one sample, hold it until accepted, then wait for its code.
  task automatic send(input int sample, input int mode);
    bit accepted = 1'b0;
    int n = 0;
    pcm = 12'(sample);
    pcm_valid = 1'b1;
    while (!(accepted && m_busy < 0)) begin
      step(cen_for(mode));
      if (last_acc) begin
        accepted = 1'b1;
        pcm_valid = 1'b0;
      end
      n++;
      if (n > 400) begin
        checks++;
        errors++;
        $error("FAIL send_timeout: observed no completion expected completion within 400 clks");
        break;
      end
    end
    pcm_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    real s;
    int p0, n_cen;
    s = 16.0;
    for (int i = 0; i < 49; i++) begin
      tbl[i] = $rtoi(s);
      s = s * 1.1;
    end
    rst = 1'b0; cen = 1'b0; pcm = '0; pcm_valid = 1'b0;

    do_reset();
    chk("rst_ready", ready, 1);
    chk("rst_code", code, 0);
    chk("rst_recon", recon, 0);

    send(0, 0);
    chk("enc0_code", code, 4'h0);
    chk("enc0_latency", obs_lat, 4);
`ifdef JT5205_ENC_RECON_EN
    chk("enc0_recon", recon, 12'd2);
`endif

    do_reset();
    send(100, 0);
    chk("p100a_code", code, 4'h7);
`ifdef JT5205_ENC_RECON_EN
    chk("p100a_recon", recon, 12'd30);
`endif
    send(100, 0);
    chk("p100b_code", code, 4'h7);
`ifdef JT5205_ENC_RECON_EN
    chk("p100b_recon", recon, 12'd93);
`endif

    do_reset();
    send(-100, 1);
    chk("m100_code", code, 4'hF);
    chk("m100_latency", obs_lat, 4);
`ifdef JT5205_ENC_RECON_EN
    chk("m100_recon", recon, 12'hFE2);
`endif

    do_reset();
    for (int i = 0; i < 60; i++) send(2047, 1);
    chk("satp_code", code, 4'h0);
`ifdef JT5205_ENC_RECON_EN
    chk("satp_recon", recon, 12'd2047);
`endif

    do_reset();
    for (int i = 0; i < 60; i++) send(-2048, 2);

    // Continuous pcm_valid with cen on every 4th clk.
    do_reset();
    pcm = 12'd300;
    pcm_valid = 1'b1;
    p0 = pulses;
    n_cen = 0;
    for (int i = 0; i < 200; i++) begin
      bit c;
      c = ((i % 4) == 3);
      step(c);
      if (c) n_cen++;
    end
    pcm_valid = 1'b0;
    chk("hs_pulses", pulses - p0, n_cen / 5);
    for (int i = 0; i < 40 && m_busy >= 0; i++) step(1'b1);

    // Reset while in B1 aborts the encode.
    do_reset();
    pcm = 12'd500;
    pcm_valid = 1'b1;
    step(1'b1);
    pcm_valid = 1'b0;
    step(1'b1);
    p0 = pulses;
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    for (int i = 0; i < 6; i++) step(1'b1);
    chk("abort_nopulse", pulses - p0, 0);
    send(0, 0);
    chk("abort_code0", code, 4'h0);

    // Random samples, cen patterns and idle gaps.
    for (int i = 0; i < 250; i++) begin
      send(int'($signed(12'($urandom_range(0, 4095)))), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
